// File: rtl/tx_comando.sv
// tx_comando: UART transmitter feeding the command receiver.
// Accepts command bytes on a valid/ready handshake, buffers them and sends
// each as start + 8 data bits (LSB first) + stop, followed by an idle-high
// guard gap so the receiver can execute the command before the next frame.
//
// Build option TX_FIFO_EN: when defined the buffer is a 4-entry circular
// FIFO; when undefined it is a single holding register (nivel is 0 or 1).
//
// Handshake: a byte is transferred on a rising edge where valido && pronto.
// valido while pronto is low is ignored; the byte is dropped silently.
module tx_comando #(
    parameter int CLKS_POR_BIT = 2,
    parameter int GUARDA       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dado,
    input  logic       valido,
    output logic       pronto,
    output logic       serial,
    output logic       ocupado,
    output logic [2:0] nivel,
    output logic [2:0] estado
);

    localparam int CW = (CLKS_POR_BIT > 1) ? $clog2(CLKS_POR_BIT) : 1;
    localparam int GW = (GUARDA > 0) ? $clog2(GUARDA + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_POR_BIT - 1);
    localparam logic [GW-1:0] GRD_MAX = GW'((GUARDA > 0) ? GUARDA - 1 : 0);

    typedef enum logic [2:0] {
        ST_OCIOSO = 3'd0,
        ST_START  = 3'd1,
        ST_DADOS  = 3'd2,
        ST_STOP   = 3'd3,
        ST_GUARDA = 3'd4
    } estado_t;

    estado_t        state_q, state_d;
    logic [CW-1:0]  ccnt_q, ccnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [7:0]     shift_q, shift_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic           serial_d;
    logic           ocupado_d;
    logic           bit_fim;

    logic           wr_en;
    logic           pop;
    logic [7:0]     head;

    assign wr_en  = valido && pronto;
    // The buffer head is consumed on the edge the FSM leaves OCIOSO.
    assign pop    = (state_q == ST_OCIOSO) && (nivel != 3'd0);
    assign estado = state_q;

`ifdef TX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wp;
    logic [1:0] rp;
    logic [2:0] cnt;

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wp] <= dado;
        end
    end

    // FIFO pointers and occupancy; write and pop on one edge leave cnt unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp  <= 2'd0;
            rp  <= 2'd0;
            cnt <= 3'd0;
        end else begin
            if (wr_en) wp <= wp + 2'd1;
            if (pop)   rp <= rp + 2'd1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head   = mem[rp];
    assign nivel  = cnt;
    assign pronto = (cnt != 3'd4);
`else
    logic [7:0] hold;
    logic       cheio;

    // Single holding register; write needs it empty and pop needs it full,
    // so the two can never coincide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold  <= 8'h00;
            cheio <= 1'b0;
        end else if (wr_en) begin
            hold  <= dado;
            cheio <= 1'b1;
        end else if (pop) begin
            cheio <= 1'b0;
        end
    end

    assign head   = hold;
    assign nivel  = {2'b00, cheio};
    assign pronto = !cheio;
`endif

    // State register: FSM, counters, shift register and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_OCIOSO;
            ccnt_q  <= '0;
            bidx_q  <= 3'd0;
            shift_q <= 8'h00;
            gcnt_q  <= '0;
            serial  <= 1'b1;
            ocupado <= 1'b0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            gcnt_q  <= gcnt_d;
            serial  <= serial_d;
            ocupado <= ocupado_d;
        end
    end

    // Next-state logic: frame sequencing and bit/guard timing
    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        gcnt_d  = gcnt_q;
        bit_fim = (ccnt_q == CNT_MAX);
        case (state_q)
            ST_OCIOSO: begin
                if (pop) begin
                    shift_d = head;
                    ccnt_d  = '0;
                    bidx_d  = 3'd0;
                    gcnt_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_fim) begin
                    ccnt_d  = '0;
                    state_d = ST_DADOS;
                end else begin
                    ccnt_d = ccnt_q + CW'(1);
                end
            end
            ST_DADOS: begin
                if (bit_fim) begin
                    ccnt_d = '0;
                    if (bidx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bidx_d  = bidx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    ccnt_d = ccnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_fim) begin
                    ccnt_d  = '0;
                    gcnt_d  = '0;
                    state_d = (GUARDA > 0) ? ST_GUARDA : ST_OCIOSO;
                end else begin
                    ccnt_d = ccnt_q + CW'(1);
                end
            end
            ST_GUARDA: begin
                if (gcnt_q == GRD_MAX) begin
                    state_d = ST_OCIOSO;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = ST_OCIOSO;
        endcase
    end

    // Output logic: line level and busy flag computed for the upcoming state
    always_comb begin
        case (state_d)
            ST_START: serial_d = 1'b0;
            ST_DADOS: serial_d = shift_d[0];
            default:  serial_d = 1'b1;
        endcase
        // Uses the current buffer level so a byte accepted this edge only
        // raises ocupado one edge later, together with the pop.
        ocupado_d = (state_d != ST_OCIOSO) || (nivel != 3'd0);
    end

endmodule

// File: tb/tb_tx_comando.sv
// tb_tx_comando: directed bench for tx_comando.
// dut  : CLKS_POR_BIT=2, GUARDA=4 (period 25 cycles)
// dut1 : CLKS_POR_BIT=1, GUARDA=0 (period 11 cycles)
// Outputs are sampled 1 time unit after each rising edge.
module tb_tx_comando;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] dado   = 8'h00;
    logic       valido = 1'b0;
    logic       pronto, serial, ocupado;
    logic [2:0] nivel, estado;

    logic [7:0] dado1   = 8'h00;
    logic       valido1 = 1'b0;
    logic       pronto1, serial1, ocupado1;
    logic [2:0] nivel1, estado1;

    tx_comando #(.CLKS_POR_BIT(2), .GUARDA(4)) dut (
        .clock(clock), .reset(reset), .dado(dado), .valido(valido),
        .pronto(pronto), .serial(serial), .ocupado(ocupado),
        .nivel(nivel), .estado(estado)
    );

    tx_comando #(.CLKS_POR_BIT(1), .GUARDA(0)) dut1 (
        .clock(clock), .reset(reset), .dado(dado1), .valido(valido1),
        .pronto(pronto1), .serial(serial1), .ocupado(ocupado1),
        .nivel(nivel1), .estado(estado1)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic ser(input int w);
        return (w == 0) ? serial : serial1;
    endfunction

    function automatic logic prn(input int w);
        return (w == 0) ? pronto : pronto1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver ----------------
    // Holds the byte until pronto allows the transfer; returns 1 unit after
    // the accepting edge with valido dropped.
    task automatic push(input int w, input logic [7:0] b);
        int n = 0;
        if (w == 0) begin dado = b; valido = 1'b1; end
        else        begin dado1 = b; valido1 = 1'b1; end
        while (!prn(w) && n < 200) begin
            tick();
            n++;
        end
        check("push_ready", 32'(n < 200), 1);
        tick();
        if (w == 0) begin valido = 1'b0; exp_q.push_back(b); end
        else        begin valido1 = 1'b0; exp1_q.push_back(b); end
    endtask

    // ---------------- line receiver ----------------
    task automatic wait_start(input int w, output int t);
        int n = 0;
        while (ser(w) !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check("start_seen", 32'(n < 300), 1);
        t = cyc;
    endtask

    // Called on the first start-bit sample; consumes 10*c samples.
    task automatic frame(input int w, input int c);
        logic [9:0] lv;
        logic [7:0] e;
        logic       s;
        int         bad;
        bad = 0;
        lv  = '0;
        e   = 8'h00;
        if (w == 0) begin
            check("sb_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else begin
            check("sb_pending1", 32'(exp1_q.size() > 0), 1);
            if (exp1_q.size() > 0) e = exp1_q.pop_front();
        end
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < c; j++) begin
                if (b != 0 || j != 0) tick();
                s = ser(w);
                if (j == 0) lv[b] = s;
                else if (s !== lv[b]) bad++;
            end
        end
        check("frame_start_bit", 32'(lv[0]), 0);
        check("frame_stop_bit", 32'(lv[9]), 1);
        check("frame_byte", 32'(lv[8:1]), 32'(e));
        check("frame_bit_hold", bad, 0);
    endtask

    task automatic idle_watch(input string tag, input int n);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (serial !== 1'b1 || serial1 !== 1'b1) errs++;
        end
        check(tag, errs, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset_idle();
        int errs = 0;
        check("rst_serial", 32'(serial), 1);
        check("rst_pronto", 32'(pronto), 1);
        check("rst_ocupado", 32'(ocupado), 0);
        check("rst_nivel", 32'(nivel), 0);
        check("rst_estado", 32'(estado), 0);
        check("rst_serial1", 32'(serial1), 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({serial, pronto, ocupado, nivel} !== {1'b1, 1'b1, 1'b0, 3'd0}) errs++;
            if ({serial1, pronto1, ocupado1, nivel1} !== {1'b1, 1'b1, 1'b0, 3'd0}) errs++;
        end
        check("idle_hold_50", errs, 0);
    endtask

    task automatic test_single();
        push(0, 8'h25);
        // accepting edge: byte stored, FSM still idle
        check("t25_acc_serial", 32'(serial), 1);
        check("t25_acc_ocupado", 32'(ocupado), 0);
        check("t25_acc_nivel", 32'(nivel), 1);
`ifdef TX_FIFO_EN
        check("t25_acc_pronto", 32'(pronto), 1);
`else
        check("t25_acc_pronto", 32'(pronto), 0);
`endif
        tick();
        check("t25_start_edge", 32'(serial), 0);
        check("t25_ocupado_up", 32'(ocupado), 1);
        check("t25_popped", 32'(nivel), 0);
        check("t25_pronto_back", 32'(pronto), 1);
        frame(0, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t25_guard_serial", 32'(serial), 1);
            check("t25_guard_ocupado", 32'(ocupado), 1);
        end
        tick();
        check("t25_ocupado_end", 32'(ocupado), 0);
        tick();
        check("t25_estado_idle", 32'(estado), 0);
    endtask

    task automatic test_queue();
        int ts[5];
        int nfr;
`ifdef TX_FIFO_EN
        // Six pushes on consecutive edges. The first pop coincides with the
        // second write, so four stay buffered after the fifth write and only
        // the sixth meets pronto=0.
        logic [7:0] vec[6];
        int         exp_nv[6];
        vec    = '{8'h1F, 8'h2A, 8'h40, 8'h25, 8'h11, 8'h77};
        exp_nv = '{1, 1, 2, 3, 4, 4};
        nfr    = 5;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    dado   = vec[i];
                    valido = 1'b1;
                    check("q_pronto", 32'(pronto), 32'(i < 5));
                    if (i < 5) exp_q.push_back(vec[i]);
                    tick();
                    check("q_nivel", 32'(nivel), exp_nv[i]);
                end
                valido = 1'b0;
            end
            begin
                for (int f = 0; f < nfr; f++) begin
                    wait_start(0, ts[f]);
                    if (f > 0) check("q_spacing", ts[f] - ts[f-1], 25);
                    frame(0, 2);
                end
            end
        join
`else
        nfr = 2;
        fork
            begin
                dado   = 8'h1F;
                valido = 1'b1;
                check("h_pronto_a", 32'(pronto), 1);
                exp_q.push_back(8'h1F);
                tick();
                check("h_pronto_b", 32'(pronto), 0);
                check("h_nivel_b", 32'(nivel), 1);
                dado = 8'h2A;
                tick();
                // refused on this edge; the pop of 0x1F frees the register
                check("h_pronto_c", 32'(pronto), 1);
                check("h_nivel_c", 32'(nivel), 0);
                exp_q.push_back(8'h2A);
                tick();
                check("h_pronto_d", 32'(pronto), 0);
                check("h_nivel_d", 32'(nivel), 1);
                valido = 1'b0;
            end
            begin
                for (int f = 0; f < nfr; f++) begin
                    wait_start(0, ts[f]);
                    if (f > 0) check("h_spacing", ts[f] - ts[f-1], 25);
                    frame(0, 2);
                end
            end
        join
`endif
        idle_watch("q_no_extra_frame", 30);
        check("q_ocupado_end", 32'(ocupado), 0);
        check("q_nivel_end", 32'(nivel), 0);
        check("q_sb_drained", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid();
        int t0;
        int errs = 0;
        fork
            begin
                push(0, 8'h4C);
                push(0, 8'h11);
`ifdef TX_FIFO_EN
                push(0, 8'h22);
`endif
            end
            begin
                wait_start(0, t0);
                // start 2 samples, bits 0..2 six samples: now on bit 3
                repeat (8) tick();
                check("r_bit3", 32'(serial), 1);
                check("r_estado_dados", 32'(estado), 2);
`ifdef TX_FIFO_EN
                check("r_nivel_pre", 32'(nivel), 2);
`else
                check("r_nivel_pre", 32'(nivel), 1);
`endif
            end
        join
        reset = 1'b1;
        #1;
        check("r_serial", 32'(serial), 1);
        check("r_nivel", 32'(nivel), 0);
        check("r_pronto", 32'(pronto), 1);
        check("r_ocupado", 32'(ocupado), 0);
        check("r_estado", 32'(estado), 0);
        exp_q.delete();
        exp1_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (serial !== 1'b1 || ocupado !== 1'b0 || nivel !== 3'd0) errs++;
        end
        check("r_quiet_after", errs, 0);
    endtask

    task automatic test_stream();
        int         ts1[3];
        logic [7:0] sv[3];
        sv = '{8'h41, 8'h12, 8'h2C};
        fork
            begin
                for (int i = 0; i < 3; i++) push(1, sv[i]);
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    wait_start(1, ts1[f]);
                    if (f > 0) check("s_spacing", ts1[f] - ts1[f-1], 11);
                    frame(1, 1);
                end
            end
        join
        idle_watch("s_idle_after", 20);
        check("s_ocupado_end", 32'(ocupado1), 0);
        check("s_sb_drained", exp1_q.size(), 0);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        test_reset_idle();
        test_single();
        test_queue();
        test_reset_mid();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
